// File: rtl/pc_fetch_unit_if.sv
// rtl/pc_fetch_unit_if.sv - instruction-memory req/ack fetch bus
interface pc_fetch_unit_if;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_ack;
    logic [31:0] im_rdata;

    modport master (
        output im_req,
        output im_addr,
        input  im_ack,
        input  im_rdata
    );

    modport slave (
        input  im_req,
        input  im_addr,
        output im_ack,
        output im_rdata
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - architectural PC register, req/ack instruction fetch and sticky fetch-error trap
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] IM_BASE  = 32'h0000_3000,
    parameter int          IM_WORDS = 4096,
    parameter int          TIMEOUT  = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [31:0]            npc,
    input  logic                   advance,
    output logic [31:0]            pc,
    pc_fetch_unit_if.master        im,
    output logic [31:0]            instr,
    output logic                   instr_valid,
    output logic                   fetch_err,
    output logic [1:0]             err_code
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

    // 33-bit window bounds so a window ending exactly at 4 GiB cannot wrap
    localparam logic [32:0] WIN_LO = {1'b0, IM_BASE};
    localparam logic [32:0] WIN_HI = {1'b0, IM_BASE} + 33'(4 * IM_WORDS);

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_ALIGN = 2'b01;
    localparam logic [1:0] ERR_RANGE = 2'b10;
    localparam logic [1:0] ERR_TIME  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_REQ   = 2'b01,
        S_VALID = 2'b10,
        S_ERR   = 2'b11
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      instr_q, instr_d;
    logic [1:0]       err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Misalignment outranks the range check
    function automatic logic [1:0] addr_check(input logic [31:0] addr);
        logic [32:0] a;
        a = {1'b0, addr};
        if (addr[1:0] != 2'b00)
            return ERR_ALIGN;
        else if (a < WIN_LO || a >= WIN_HI)
            return ERR_RANGE;
        else
            return ERR_NONE;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= 32'h0;
            err_q   <= ERR_NONE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        logic [1:0] chk;
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        chk     = ERR_NONE;

        case (state_q)
            S_IDLE: begin
                chk = addr_check(pc_q);
                cnt_d = '0;
                if (chk == ERR_NONE) begin
                    state_d = S_REQ;
                end else begin
                    state_d = S_ERR;
                    err_d   = chk;
                end
            end

            S_REQ: begin
                if (im.im_ack) begin
                    instr_d = im.im_rdata;
                    state_d = S_VALID;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = S_ERR;
                    err_d   = ERR_TIME;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_VALID: begin
                if (advance) begin
                    // pc takes npc even when it is bad, so the trap shows the offending address
                    pc_d  = npc;
                    chk   = addr_check(npc);
                    cnt_d = '0;
                    if (chk == ERR_NONE) begin
                        state_d = S_REQ;
                    end else begin
                        state_d = S_ERR;
                        err_d   = chk;
                    end
                end
            end

            S_ERR: begin
                state_d = S_ERR;
            end

            default: begin
                state_d = S_ERR;
            end
        endcase
    end

    assign pc          = pc_q;
    assign im.im_req   = (state_q == S_REQ);
    assign im.im_addr  = pc_q;
    assign instr       = instr_q;
    assign instr_valid = (state_q == S_VALID);
    assign fetch_err   = (state_q == S_ERR);
    assign err_code    = err_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - directed table-driven bench for pc_fetch_unit
module tb_pc_fetch_unit;

    logic        clk;
    logic        reset_n;
    logic [31:0] npc;
    logic        advance;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        instr_valid;
    logic        fetch_err;
    logic [1:0]  err_code;

    pc_fetch_unit_if im_bus ();

    pc_fetch_unit dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .npc         (npc),
        .advance     (advance),
        .pc          (pc),
        .im          (im_bus.master),
        .instr       (instr),
        .instr_valid (instr_valid),
        .fetch_err   (fetch_err),
        .err_code    (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] npc;
        int          delay;
        logic [31:0] rdata;
        logic [1:0]  code;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        advance = 1'b0;
        im_bus.im_ack = 1'b0;
        #1;
        chk("rst_pc", pc, 32'h3000);
        chk("rst_im_req", {31'b0, im_bus.im_req}, 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_fetch_err", {31'b0, fetch_err}, 32'd0);
        chk("rst_err_code", {30'b0, err_code}, 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        chk("post_rst_im_req", {31'b0, im_bus.im_req}, 32'd1);
        chk("post_rst_im_addr", im_bus.im_addr, 32'h3000);
    endtask

    // Called in S_REQ at a negedge; waits `delay` cycles, then acks with rdata
    task automatic fetch(input logic [31:0] addr, input int delay, input logic [31:0] rdata);
        for (int i = 0; i < delay; i++) begin
            chk("wait_im_req", {31'b0, im_bus.im_req}, 32'd1);
            chk("wait_im_addr", im_bus.im_addr, addr);
            chk("wait_instr_valid", {31'b0, instr_valid}, 32'd0);
            tick();
        end
        im_bus.im_ack   = 1'b1;
        im_bus.im_rdata = rdata;
        tick();
        im_bus.im_ack   = 1'b0;
        im_bus.im_rdata = 32'hFFFF_FFFF;
        chk("fetch_instr", instr, rdata);
        chk("fetch_instr_valid", {31'b0, instr_valid}, 32'd1);
        chk("fetch_im_req_low", {31'b0, im_bus.im_req}, 32'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        npc = 32'h0;
        advance = 1'b0;
        im_bus.im_ack = 1'b0;
        im_bus.im_rdata = 32'h0;

        vecs[0] = '{npc: 32'h0000_3004, delay: 3, rdata: 32'h8C22_0004, code: 2'b00};
        vecs[1] = '{npc: 32'h0000_6FFC, delay: 0, rdata: 32'h0123_4567, code: 2'b00};
        vecs[2] = '{npc: 32'h0000_3002, delay: 0, rdata: 32'h0,         code: 2'b01};
        vecs[3] = '{npc: 32'h0000_7000, delay: 0, rdata: 32'h0,         code: 2'b10};
        vecs[4] = '{npc: 32'h0000_2FFC, delay: 0, rdata: 32'h0,         code: 2'b10};
        vecs[5] = '{npc: 32'h0000_0001, delay: 0, rdata: 32'h0,         code: 2'b01};
        vecs[6] = '{npc: 32'h0000_3000, delay: 1, rdata: 32'hA5A5_5A5A, code: 2'b00};
        vecs[7] = '{npc: 32'hFFFF_FFFC, delay: 0, rdata: 32'h0,         code: 2'b10};

        tick();
        tick();

        for (int v = 0; v < 8; v++) begin
            do_reset();
            fetch(32'h3000, 0, 32'h3C01_1234);
            npc = vecs[v].npc;
            advance = 1'b1;
            tick();
            advance = 1'b0;
            chk("adv_pc", pc, vecs[v].npc);
            chk("adv_instr_valid_drop", {31'b0, instr_valid}, 32'd0);
            if (vecs[v].code == 2'b00) begin
                chk("adv_im_req", {31'b0, im_bus.im_req}, 32'd1);
                fetch(vecs[v].npc, vecs[v].delay, vecs[v].rdata);
            end else begin
                chk("err_flag", {31'b0, fetch_err}, 32'd1);
                chk("err_code", {30'b0, err_code}, {30'b0, vecs[v].code});
                chk("err_im_req", {31'b0, im_bus.im_req}, 32'd0);
                npc = 32'h0000_3100;
                advance = 1'b1;
                im_bus.im_ack = 1'b1;
                im_bus.im_rdata = 32'hDEAD_BEEF;
                tick();
                advance = 1'b0;
                im_bus.im_ack = 1'b0;
                chk("sticky_pc", pc, vecs[v].npc);
                chk("sticky_code", {30'b0, err_code}, {30'b0, vecs[v].code});
                chk("sticky_instr", instr, 32'h3C01_1234);
                chk("sticky_valid", {31'b0, instr_valid}, 32'd0);
                chk("sticky_err", {31'b0, fetch_err}, 32'd1);
            end
        end

        // Timeout: 16 cycles in S_REQ without ack; advance inside S_REQ is ignored
        do_reset();
        for (int i = 0; i < 16; i++) begin
            chk("to_im_req", {31'b0, im_bus.im_req}, 32'd1);
            chk("to_pc", pc, 32'h3000);
            chk("to_fetch_err", {31'b0, fetch_err}, 32'd0);
            if (i == 2) begin
                npc = 32'h0000_5000;
                advance = 1'b1;
            end
            tick();
            advance = 1'b0;
        end
        chk("to_err", {31'b0, fetch_err}, 32'd1);
        chk("to_code", {30'b0, err_code}, 32'd3);
        chk("to_im_req_low", {31'b0, im_bus.im_req}, 32'd0);

        // Async reset mid-S_REQ; ack during reset must be dropped
        do_reset();
        fetch(32'h3000, 0, 32'h1111_2222);
        npc = 32'h0000_3008;
        advance = 1'b1;
        tick();
        advance = 1'b0;
        chk("mid_pc", pc, 32'h3008);
        chk("mid_im_req", {31'b0, im_bus.im_req}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("async_pc", pc, 32'h3000);
        chk("async_im_req", {31'b0, im_bus.im_req}, 32'd0);
        chk("async_instr_valid", {31'b0, instr_valid}, 32'd0);
        chk("async_instr", instr, 32'h0);
        im_bus.im_ack = 1'b1;
        im_bus.im_rdata = 32'hBAD0_BAD0;
        tick();
        im_bus.im_ack = 1'b0;
        reset_n = 1'b1;
        tick();
        chk("rel_im_req", {31'b0, im_bus.im_req}, 32'd1);
        chk("rel_im_addr", im_bus.im_addr, 32'h3000);
        chk("rel_instr", instr, 32'h0);
        chk("rel_instr_valid", {31'b0, instr_valid}, 32'd0);
        fetch(32'h3000, 2, 32'h3C01_1234);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
